// File: rtl/serial_word_sequencer.sv
// Assembles edge-detector sample pulses into fixed-width serial words and offers them on a valid/ready holding register.
// Also reports framing errors (discarded partial words) and holding-register overruns.
module serial_word_sequencer #(
   parameter int WORD_WIDTH     = 8,
   parameter bit MSB_FIRST      = 1'b1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                sys_clk,
   input  logic                                rst,
   input  logic                                en,
   input  logic                                frame_start,
   input  logic                                frame_end,
   input  logic                                sample_edge,
   input  logic                                data_bit,
   input  logic                                rx_ready,
   input  logic                                clr_status,
   output logic [WORD_WIDTH-1:0]               rx_data,
   output logic                                rx_valid,
   output logic                                busy,
   output logic [$clog2(WORD_WIDTH+1)-1:0]     bit_cnt,
   output logic                                overrun,
   output logic                                frame_err
);

   localparam int BCW = $clog2(WORD_WIDTH + 1);
   localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_WIDTH - 1);
   localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t                state_q, state_d;
   logic [WORD_WIDTH-1:0] shift_q, shift_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [WORD_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;
   logic                  frame_err_q, frame_err_d;

   logic                  word_done;
   logic                  overrun_set;
   logic                  ferr_set;
   logic [BCW-1:0]        cnt_after;

   function automatic logic [WORD_WIDTH-1:0] shift_in(input logic [WORD_WIDTH-1:0] sr,
                                                      input logic                  b);
      if (MSB_FIRST)
         return {sr[WORD_WIDTH-2:0], b};
      else
         return {b, sr[WORD_WIDTH-1:1]};
   endfunction

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      tmo_d       = tmo_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      word_done   = 1'b0;
      overrun_set = 1'b0;
      ferr_set    = 1'b0;
      cnt_after   = bit_cnt_q;

      if (rx_valid_q && rx_ready)
         rx_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            bit_cnt_d = '0;
            tmo_d     = '0;
            if (en && frame_start && !frame_end)
               state_d = S_ACTIVE;
         end

         S_ACTIVE: begin
            if (!en) begin
               state_d   = S_IDLE;
               bit_cnt_d = '0;
               tmo_d     = '0;
            end else begin
               // The bit of this cycle is absorbed before any frame event is judged.
               if (sample_edge) begin
                  shift_d = shift_in(shift_q, data_bit);
                  if (bit_cnt_q == LAST_BIT) begin
                     word_done = 1'b1;
                     cnt_after = '0;
                  end else begin
                     cnt_after = bit_cnt_q + 1'b1;
                  end
               end
               bit_cnt_d = cnt_after;
               tmo_d     = (sample_edge || !TMO_EN) ? '0 : tmo_q + 1'b1;

               if (frame_end) begin
                  ferr_set  = |cnt_after;
                  state_d   = S_IDLE;
                  bit_cnt_d = '0;
                  tmo_d     = '0;
               end else if (frame_start) begin
                  ferr_set  = |cnt_after;
                  bit_cnt_d = '0;
                  tmo_d     = '0;
               end else if (TMO_EN && !sample_edge && tmo_q == TMO_LAST) begin
                  ferr_set  = |bit_cnt_q;
                  state_d   = S_IDLE;
                  bit_cnt_d = '0;
                  tmo_d     = '0;
               end
            end
         end

         default: begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            tmo_d     = '0;
         end
      endcase

      // A completing word may replace one that is leaving this same cycle.
      if (word_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
         end else begin
            overrun_set = 1'b1;
         end
      end

      overrun_d   = overrun_set | (overrun_q & ~clr_status);
      frame_err_d = ferr_set | (frame_err_q & ~clr_status);
      busy_d      = (state_d == S_ACTIVE);
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         tmo_q       <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         tmo_q       <= tmo_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign busy      = busy_q;
   assign bit_cnt   = bit_cnt_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_word_sequencer.sv
// Directed bench for serial_word_sequencer: an MSB-first and an LSB-first instance share one stimulus stream.
// Expected words are queued when driven and compared when the DUT hands them over.
module tb_serial_word_sequencer;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       frame_start = 1'b0;
   logic       frame_end = 1'b0;
   logic       sample_edge = 1'b0;
   logic       data_bit = 1'b0;
   logic       rx_ready = 1'b1;
   logic       clr_status = 1'b0;

   logic [7:0] rx_data_m, rx_data_l;
   logic       rx_valid_m, rx_valid_l;
   logic       busy_m, busy_l;
   logic [3:0] bit_cnt_m, bit_cnt_l;
   logic       overrun_m, overrun_l;
   logic       frame_err_m, frame_err_l;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_m[$];
   logic [7:0] exp_l[$];

   always #5 sys_clk = ~sys_clk;

   serial_word_sequencer #(.WORD_WIDTH(8), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(16)) dut_m (
      .sys_clk(sys_clk), .rst(rst), .en(en), .frame_start(frame_start), .frame_end(frame_end),
      .sample_edge(sample_edge), .data_bit(data_bit), .rx_ready(rx_ready), .clr_status(clr_status),
      .rx_data(rx_data_m), .rx_valid(rx_valid_m), .busy(busy_m), .bit_cnt(bit_cnt_m),
      .overrun(overrun_m), .frame_err(frame_err_m));

   serial_word_sequencer #(.WORD_WIDTH(8), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(16)) dut_l (
      .sys_clk(sys_clk), .rst(rst), .en(en), .frame_start(frame_start), .frame_end(frame_end),
      .sample_edge(sample_edge), .data_bit(data_bit), .rx_ready(rx_ready), .clr_status(clr_status),
      .rx_data(rx_data_l), .rx_valid(rx_valid_l), .busy(busy_l), .bit_cnt(bit_cnt_l),
      .overrun(overrun_l), .frame_err(frame_err_l));

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [7:0] w);
      exp_m.push_back(w);
      exp_l.push_back(rev8(w));
   endtask

   // One clock: handshake sampled on the falling edge, return just after the rising edge.
   task automatic cyc();
      @(negedge sys_clk);
      if (rx_valid_m && rx_ready) begin
         chk("sb_m_nonempty", 32'(exp_m.size() > 0), 1);
         if (exp_m.size() > 0) chk("sb_m_word", 32'(rx_data_m), 32'(exp_m.pop_front()));
      end
      if (rx_valid_l && rx_ready) begin
         chk("sb_l_nonempty", 32'(exp_l.size() > 0), 1);
         if (exp_l.size() > 0) chk("sb_l_word", 32'(rx_data_l), 32'(exp_l.pop_front()));
      end
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sample_edge = 1'b1;
      data_bit    = b;
      cyc();
      sample_edge = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
   endtask

   task automatic pulse_end();
      frame_end = 1'b1;
      cyc();
      frame_end = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_status = 1'b1;
      cyc();
      clr_status = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_rx_data", 32'(rx_data_m), 0);
      chk("rst_rx_valid", 32'(rx_valid_m), 0);
      chk("rst_busy", 32'(busy_m), 0);
      chk("rst_bit_cnt", 32'(bit_cnt_m), 0);
      chk("rst_overrun", 32'(overrun_m), 0);
      chk("rst_frame_err", 32'(frame_err_m), 0);
      rst = 1'b0;
      cyc();

      // Basic MSB/LSB word assembly
      pulse_start();
      chk("start_busy", 32'(busy_m), 1);
      push_word(8'hA5);
      send_bits(8'hA5, 8);
      chk("a5_valid", 32'(rx_valid_m), 1);
      chk("a5_data_m", 32'(rx_data_m), 'hA5);
      chk("a5_data_l", 32'(rx_data_l), 'hA5);
      cyc();
      chk("a5_valid_drop", 32'(rx_valid_m), 0);
      chk("a5_overrun", 32'(overrun_m), 0);
      chk("a5_frame_err", 32'(frame_err_m), 0);
      push_word(8'hC0);
      send_bits(8'hC0, 8);
      chk("c0_data_m", 32'(rx_data_m), 'hC0);
      chk("c0_data_l", 32'(rx_data_l), 'h03);
      cyc();

      // Overrun with consumer stalled
      rx_ready = 1'b0;
      push_word(8'h11);
      send_bits(8'h11, 8);
      chk("ovr_first_valid", 32'(rx_valid_m), 1);
      send_bits(8'h22, 8);
      chk("ovr_hold_m", 32'(rx_data_m), 'h11);
      chk("ovr_hold_l", 32'(rx_data_l), 'h88);
      chk("ovr_flag_m", 32'(overrun_m), 1);
      chk("ovr_flag_l", 32'(overrun_l), 1);
      pulse_clr();
      chk("ovr_cleared", 32'(overrun_m), 0);
      rx_ready = 1'b1;
      cyc();
      chk("ovr_drained", 32'(rx_valid_m), 0);
      pulse_end();
      chk("end_clean_busy", 32'(busy_m), 0);
      chk("end_clean_ferr", 32'(frame_err_m), 0);

      // Early frame end discards partial
      pulse_start();
      send_bits(8'h15, 5);
      chk("part_bit_cnt", 32'(bit_cnt_m), 5);
      pulse_end();
      chk("early_ferr", 32'(frame_err_m), 1);
      chk("early_busy", 32'(busy_m), 0);
      chk("early_valid", 32'(rx_valid_m), 0);
      chk("early_bit_cnt", 32'(bit_cnt_m), 0);
      pulse_clr();
      chk("ferr_cleared", 32'(frame_err_m), 0);

      // Frame end coincident with final bit delivers the word
      pulse_start();
      push_word(8'h96);
      send_bits(8'h4B, 7);
      sample_edge = 1'b1;
      data_bit    = 1'b0;
      frame_end   = 1'b1;
      cyc();
      sample_edge = 1'b0;
      frame_end   = 1'b0;
      chk("coend_valid", 32'(rx_valid_m), 1);
      chk("coend_data", 32'(rx_data_m), 'h96);
      chk("coend_busy", 32'(busy_m), 0);
      chk("coend_ferr", 32'(frame_err_m), 0);
      cyc();

      // Start and end together in IDLE, and start while disabled, are ignored
      frame_start = 1'b1;
      frame_end   = 1'b1;
      cyc();
      frame_start = 1'b0;
      frame_end   = 1'b0;
      chk("idle_both_busy", 32'(busy_m), 0);
      en = 1'b0;
      pulse_start();
      en = 1'b1;
      chk("dis_start_busy", 32'(busy_m), 0);

      // Timeout with partial word
      pulse_start();
      send_bits(8'h05, 3);
      repeat (15) cyc();
      chk("tmo_not_yet", 32'(busy_m), 1);
      cyc();
      chk("tmo_busy", 32'(busy_m), 0);
      chk("tmo_ferr", 32'(frame_err_m), 1);
      chk("tmo_bit_cnt", 32'(bit_cnt_m), 0);
      pulse_clr();

      // Timeout with no bits: abort without error
      pulse_start();
      repeat (16) cyc();
      chk("tmo0_busy", 32'(busy_m), 0);
      chk("tmo0_ferr", 32'(frame_err_m), 0);

      // Disable mid-word
      pulse_start();
      send_bits(8'h06, 3);
      en = 1'b0;
      cyc();
      en = 1'b1;
      chk("en_busy", 32'(busy_m), 0);
      chk("en_bit_cnt", 32'(bit_cnt_m), 0);
      chk("en_ferr", 32'(frame_err_m), 0);

      // Restart mid-word, then a clean word aligned to the restart
      pulse_start();
      send_bits(8'h0A, 4);
      pulse_start();
      chk("restart_busy", 32'(busy_m), 1);
      chk("restart_ferr", 32'(frame_err_m), 1);
      chk("restart_bit_cnt", 32'(bit_cnt_m), 0);
      pulse_clr();
      push_word(8'h3C);
      send_bits(8'h3C, 8);
      chk("restart_word", 32'(rx_data_m), 'h3C);
      cyc();
      pulse_end();

      // Back-to-back 16 bits, second completion coincides with transfer
      pulse_start();
      rx_ready = 1'b0;
      push_word(8'hFF);
      push_word(8'h00);
      send_bits(8'hFF, 8);
      send_bits(8'h00, 7);
      rx_ready = 1'b1;
      send_bit(1'b0);
      chk("b2b_valid_kept", 32'(rx_valid_m), 1);
      chk("b2b_data", 32'(rx_data_m), 'h00);
      chk("b2b_overrun", 32'(overrun_m), 0);
      cyc();
      chk("b2b_valid_drop", 32'(rx_valid_m), 0);
      pulse_end();

      // Asynchronous reset mid-word with a held word
      rx_ready = 1'b0;
      pulse_start();
      send_bits(8'h5A, 8);
      send_bits(8'h03, 3);
      chk("pre_rst_valid", 32'(rx_valid_m), 1);
      chk("pre_rst_data", 32'(rx_data_m), 'h5A);
      chk("pre_rst_bit_cnt", 32'(bit_cnt_m), 3);
      rst = 1'b1;
      #1;
      chk("arst_rx_data", 32'(rx_data_m), 0);
      chk("arst_rx_valid", 32'(rx_valid_m), 0);
      chk("arst_busy", 32'(busy_m), 0);
      chk("arst_bit_cnt", 32'(bit_cnt_m), 0);
      chk("arst_flags", 32'({overrun_m, frame_err_m}), 0);
      @(posedge sys_clk);
      #1;
      rst      = 1'b0;
      rx_ready = 1'b1;
      cyc();
      chk("post_rst_busy", 32'(busy_m), 0);

      chk("sb_m_empty", 32'(exp_m.size()), 0);
      chk("sb_l_empty", 32'(exp_l.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
